// File: rtl/burst_pkg.sv
// Shared types and constants for the burst last-flag tagger.
package burst_pkg;

   localparam int unsigned BURST_LEN_WIDTH = 8;

   typedef logic [BURST_LEN_WIDTH-1:0] burst_len_t;
   typedef logic [31:0]                stat_cnt_t;

   localparam burst_len_t BURST_LEN_ONE_BEAT = '0;

endpackage

// File: rtl/burst_desc_fifo.sv
// Register-array descriptor FIFO; a push is accepted while full if a pop happens in the same cycle.
module burst_desc_fifo #(
   parameter int unsigned Width     = 8,
   parameter int unsigned DepthLog2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned Depth = 1 << DepthLog2;

   logic [Width-1:0]     mem_q [Depth];
   logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DepthLog2:0]   cnt_q, cnt_d;
   logic                 do_push, do_pop;

   always_comb begin
      full_o   = (cnt_q == (DepthLog2 + 1)'(Depth));
      empty_o  = (cnt_q == '0);
      rdata_o  = mem_q[rd_ptr_q];
      do_pop   = pop_i & ~empty_o;
      do_push  = push_i & (~full_o | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/burst_last_tagger.sv
// Tags a beat stream with per-burst last flags from prefetched length descriptors.
// Optional statistics counters are enabled by defining BURST_LAST_TAGGER_STATS_EN.
module burst_last_tagger
   import burst_pkg::*;
#(
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned BurstLenWidth = BURST_LEN_WIDTH,
   parameter int unsigned DescDepthLog2 = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [BurstLenWidth-1:0] burst_len_dout,
   input  logic                     burst_len_empty_n,
   output logic                     burst_len_read,
   input  logic [DataWidth-1:0]     data_dout,
   input  logic                     data_empty_n,
   output logic                     data_read,
   output logic [DataWidth-1:0]     out_data_din,
   output logic                     out_last_din,
   input  logic                     out_full_n,
`ifdef BURST_LAST_TAGGER_STATS_EN
   output stat_cnt_t                stat_bursts,
   output stat_cnt_t                stat_beats,
`endif
   output logic                     out_write
);

   logic [BurstLenWidth-1:0] head, eff_count;
   logic [BurstLenWidth-1:0] count_q, count_d;
   logic                     active_q, active_d;
   logic                     fifo_empty, fifo_full;
   logic                     eff_active, is_last, fire, retire;

   burst_desc_fifo #(
      .Width     (BurstLenWidth),
      .DepthLog2 (DescDepthLog2)
   ) u_desc_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (burst_len_read),
      .wdata_i (burst_len_dout),
      .pop_i   (retire),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // While idle the queue head is used directly, so a burst starts in the cycle it appears.
   always_comb begin
      eff_active = active_q | ~fifo_empty;
      eff_count  = active_q ? count_q : head;
      is_last    = eff_active & (eff_count == BurstLenWidth'(BURST_LEN_ONE_BEAT));
      fire       = eff_active & data_empty_n & out_full_n;
      retire     = fire & is_last;
      active_d   = active_q;
      count_d    = count_q;
      if (fire) begin
         if (is_last) begin
            active_d = 1'b0;
         end else begin
            active_d = 1'b1;
            count_d  = eff_count - BurstLenWidth'(1);
         end
      end
      burst_len_read = rst_n & burst_len_empty_n & (~fifo_full | retire);
      data_read      = fire;
      out_write      = fire;
      out_data_din   = data_dout;
      out_last_din   = is_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         count_q  <= '0;
      end else begin
         active_q <= active_d;
         count_q  <= count_d;
      end
   end

`ifdef BURST_LAST_TAGGER_STATS_EN
   stat_cnt_t bursts_q, beats_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bursts_q <= '0;
         beats_q  <= '0;
      end else begin
         if (retire) bursts_q <= bursts_q + 32'd1;
         if (fire)   beats_q  <= beats_q + 32'd1;
      end
   end

   assign stat_bursts = bursts_q;
   assign stat_beats  = beats_q;
`endif

endmodule

// File: tb/tb_burst_last_tagger.sv
// Randomized and directed bench for burst_last_tagger against a queue-based burst model.
module tb_burst_last_tagger;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  burst_len_dout;
   logic        burst_len_empty_n;
   logic        burst_len_read;
   logic [63:0] data_dout;
   logic        data_empty_n;
   logic        data_read;
   logic [63:0] out_data_din;
   logic        out_last_din;
   logic        out_full_n;
   logic        out_write;
`ifdef BURST_LAST_TAGGER_STATS_EN
   logic [31:0] stat_bursts, stat_beats;
`endif

   burst_last_tagger dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .burst_len_dout    (burst_len_dout),
      .burst_len_empty_n (burst_len_empty_n),
      .burst_len_read    (burst_len_read),
      .data_dout         (data_dout),
      .data_empty_n      (data_empty_n),
      .data_read         (data_read),
      .out_data_din      (out_data_din),
      .out_last_din      (out_last_din),
      .out_full_n        (out_full_n),
`ifdef BURST_LAST_TAGGER_STATS_EN
      .stat_bursts       (stat_bursts),
      .stat_beats        (stat_beats),
`endif
      .out_write         (out_write)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   // Model: each entry is the number of beats still owed by a queued burst, minus one.
   int          mq[$];
   int          src_desc[$];
   logic [63:0] src_data[$];
   bit          obs_last[$];
   int          rd_pulses;
   int unsigned exp_bursts, exp_beats;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_data(input int n);
      for (int i = 0; i < n; i++) src_data.push_back({$urandom, $urandom});
   endtask

   // One clock cycle: drive at negedge, check 1 time unit later, update model at posedge.
   task automatic step(input bit dv, input bit dsc, input bit sr);
      bit exp_fire, exp_last, exp_rd;
      burst_len_empty_n = dsc && (src_desc.size() > 0);
      burst_len_dout    = burst_len_empty_n ? 8'(src_desc[0]) : 8'($urandom);
      data_empty_n      = dv && (src_data.size() > 0);
      data_dout         = data_empty_n ? src_data[0] : {$urandom, $urandom};
      out_full_n        = sr;
      #1;
      exp_fire = (mq.size() > 0) && data_empty_n && out_full_n;
      exp_last = (mq.size() > 0) && (mq[0] == 0);
      exp_rd   = burst_len_empty_n && ((mq.size() < 4) || (exp_fire && exp_last));
      chk("burst_len_read", burst_len_read, exp_rd);
      chk("data_read", data_read, exp_fire);
      chk("out_write", out_write, exp_fire);
      chk("out_last_din", out_last_din, exp_last);
      if (exp_fire) chk("out_data_din", out_data_din, src_data[0]);
`ifdef BURST_LAST_TAGGER_STATS_EN
      chk("stat_bursts", stat_bursts, exp_bursts);
      chk("stat_beats", stat_beats, exp_beats);
`endif
      if (out_write) obs_last.push_back(out_last_din);
      if (burst_len_read) rd_pulses++;
      @(posedge clk);
      if (exp_fire) begin
         void'(src_data.pop_front());
         exp_beats++;
         if (exp_last) begin
            void'(mq.pop_front());
            exp_bursts++;
         end else begin
            mq[0] = mq[0] - 1;
         end
      end
      if (exp_rd) mq.push_back(src_desc.pop_front());
      @(negedge clk);
   endtask

   task automatic run_idle(input string tag, input int max);
      int n = 0;
      while ((mq.size() > 0 || src_desc.size() > 0) && n < max) begin
         step(1'b1, 1'b1, 1'b1);
         n++;
      end
      chk({tag, "_done_in_budget"}, 64'(n < max), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_burst_len_read"}, burst_len_read, 1'b0);
      chk({tag, "_data_read"}, data_read, 1'b0);
      chk({tag, "_out_write"}, out_write, 1'b0);
      chk({tag, "_out_last_din"}, out_last_din, 1'b0);
`ifdef BURST_LAST_TAGGER_STATS_EN
      chk({tag, "_stat_bursts"}, stat_bursts, 32'd0);
      chk({tag, "_stat_beats"}, stat_beats, 32'd0);
`endif
   endtask

   initial begin
      bit p1[4];
      bit p2[5];
      bit p3[5];
      int lasts;
      p1 = '{0, 0, 0, 1};
      p2 = '{1, 0, 0, 1, 1};
      p3 = '{0, 0, 0, 0, 1};

      rst_n             = 1'b0;
      burst_len_empty_n = 1'b1;
      burst_len_dout    = 8'd3;
      data_empty_n      = 1'b1;
      data_dout         = '1;
      out_full_n        = 1'b1;
      exp_bursts        = 0;
      exp_beats         = 0;
      rd_pulses         = 0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("init");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single L=3 burst, everything ready.
      src_desc.push_back(3);
      add_data(4);
      obs_last.delete();
      run_idle("t1", 20);
      chk("t1_writes", obs_last.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t1_last%0d", i), obs_last[i], p1[i]);

      // 2: descriptors 0,2,0 queued before data arrives; no bubble once data flows.
      src_desc = '{0, 2, 0};
      repeat (4) step(1'b0, 1'b1, 1'b1);
      add_data(5);
      obs_last.delete();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
      chk("t2_writes", obs_last.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("t2_last%0d", i), obs_last[i], p2[i]);

      // 3: L=4 with a 3-cycle sink stall after the first beat.
      src_desc.push_back(4);
      add_data(5);
      obs_last.delete();
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b1, 1'b0);
      chk("t3_writes_before_release", obs_last.size(), 1);
      run_idle("t3", 20);
      chk("t3_writes", obs_last.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("t3_last%0d", i), obs_last[i], p3[i]);

      // 4: five descriptors against a depth-4 queue while data is empty.
      src_desc  = '{0, 1, 0, 2, 0};
      rd_pulses = 0;
      repeat (6) step(1'b0, 1'b1, 1'b1);
      chk("t4_reads_while_full", rd_pulses, 4);
      add_data(8);
      step(1'b1, 1'b1, 1'b1);
      chk("t4_read_on_retire", rd_pulses, 5);
      run_idle("t4", 30);
      chk("t4_data_left", src_data.size(), 0);

      // 5: maximum length descriptor.
      src_desc.push_back(255);
      add_data(256);
      obs_last.delete();
      run_idle("t5", 400);
      chk("t5_writes", obs_last.size(), 256);
      lasts = 0;
      foreach (obs_last[i]) lasts += int'(obs_last[i]);
      chk("t5_last_count", lasts, 1);
      chk("t5_last_on_final", obs_last[obs_last.size() - 1], 1'b1);

      // 6: reset during an L=5 burst, then a fresh L=1 burst.
      src_desc.push_back(5);
      add_data(6);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      src_desc.push_back(2);
      burst_len_empty_n = 1'b1;
      rst_n             = 1'b0;
      #1;
      chk_reset_outputs("t6_in_reset");
      @(negedge clk);
      chk_reset_outputs("t6_in_reset_late");
      mq.delete();
      src_desc.delete();
      src_data.delete();
      exp_bursts = 0;
      exp_beats  = 0;
      rst_n      = 1'b1;
      src_desc.push_back(1);
      add_data(2);
      obs_last.delete();
      run_idle("t6", 20);
      chk("t6_writes", obs_last.size(), 2);
      chk("t6_last0", obs_last[0], 1'b0);
      chk("t6_last1", obs_last[1], 1'b1);
`ifdef BURST_LAST_TAGGER_STATS_EN
      chk("t6_stat_bursts", stat_bursts, 32'd1);
      chk("t6_stat_beats", stat_beats, 32'd2);
`endif

      // Random traffic with random upstream and sink gating.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0 && src_desc.size() < 6)
            src_desc.push_back($urandom_range(0, 6));
         if (src_data.size() < 4 && $urandom_range(0, 1) == 1) add_data(1);
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 3) != 0));
      end
      for (int c = 0; c < 200 && (mq.size() > 0 || src_desc.size() > 0); c++) begin
         if (src_data.size() == 0) add_data(1);
         step(1'b1, 1'b1, 1'b1);
      end
      chk("rand_drained", mq.size() + src_desc.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
